// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   Buffered asynchronous serial transmitter. Producers push words into a
//   small FIFO over a valid/ready handshake. Each word is sent as a frame
//   made of a start bit, the data bits LSB first, an optional parity bit
//   and one or two stop bits. Every bit is held for CLKS_PER_BIT clocks.
//   While words remain queued, frames follow each other with no idle gap.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high; line goes idle (high) at once
//   in_data     in   word to transmit (DATA_BITS wide)
//   in_valid    in   in_data is valid
//   in_ready    out  FIFO can accept a word this cycle
//   serial_out  out  serial line, idles high
//   busy        out  a frame is in progress
//   fifo_count  out  number of words currently buffered
module uart_frame_tx #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    // The bit timer also spans the whole stop period, so size it for that.
    localparam int TW        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
    localparam int BW        = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [DATA_BITS-1:0] w_head;

    assign in_ready   = (r_count < DEPTH_C);
    // in_ready already excludes the full case, so a pop on the same edge
    // never makes room for a push that was refused.
    assign w_push     = in_valid && in_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];

    // Storage carries no reset; stale entries are never read because the
    // count is cleared.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_busy;

    state_t               w_state_next;
    logic [TW-1:0]        w_timer_next;
    logic [BW-1:0]        w_bit_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_parity_next;
    logic                 w_serial_next;
    logic                 w_busy_next;
    logic                 w_load;
    logic                 w_bit_done;
    logic                 w_stop_done;

    assign w_bit_done  = (r_timer == BIT_LAST);
    assign w_stop_done = (r_timer == STOP_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_serial  <= w_serial_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_serial_next  = r_serial;
        w_busy_next    = r_busy;
        w_load         = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_serial_next = 1'b1;
                w_busy_next   = 1'b0;
                if (w_nonempty) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    // The shift register always presents the next data bit
                    // at position 0; shifting as each bit goes out.
                    w_timer_next   = '0;
                    w_state_next   = S_DATA;
                    w_bit_idx_next = '0;
                    w_serial_next  = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_timer_next = '0;
                    if (r_bit_idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                            w_state_next  = S_PARITY;
                            w_serial_next = r_parity;
                        end else begin
                            w_state_next  = S_STOP;
                            w_serial_next = 1'b1;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_serial_next  = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bit_done) begin
                    w_timer_next  = '0;
                    w_state_next  = S_STOP;
                    w_serial_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_STOP: begin
                // The timer runs across all stop bits as a single period.
                if (w_stop_done) begin
                    if (w_nonempty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next  = S_IDLE;
                        w_busy_next   = 1'b0;
                        w_serial_next = 1'b1;
                        w_timer_next  = '0;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_serial_next = 1'b1;
                w_busy_next   = 1'b0;
            end
        endcase

        // Common frame start, used both from idle and straight out of the
        // stop period so that consecutive frames have no gap.
        if (w_load) begin
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = (PARITY == 2) ? ~(^w_head) : (^w_head);
            w_serial_next = 1'b0;
            w_timer_next  = '0;
            w_busy_next   = 1'b1;
            w_state_next  = S_START;
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx. Four instances with different framing
// parameters share one clock and reset. Expected line waveforms are built
// from the frame rules (start, data LSB first, parity, stop bits, each held
// CLKS_PER_BIT clocks) and compared sample by sample on the falling edge.
module tb_uart_frame_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [7:0]  t_data [4];
    logic [3:0]  t_valid;
    wire  [3:0]  t_ready;
    wire  [3:0]  t_serial;
    wire  [3:0]  t_busy;
    wire  [11:0] t_count_flat;

    int cfg_cpb  [4] = '{4, 4, 2, 1};
    int cfg_par  [4] = '{0, 1, 2, 0};
    int cfg_stop [4] = '{1, 1, 1, 2};

    int n_tests;
    int n_fail;

    logic       exp_ser  [$];
    logic       exp_busy [$];
    logic       cap_ser  [$];
    logic       cap_busy [$];
    logic [2:0] cap_cnt  [$];

    uart_frame_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .in_data(t_data[0]), .in_valid(t_valid[0]),
        .in_ready(t_ready[0]), .serial_out(t_serial[0]), .busy(t_busy[0]), .fifo_count(t_count_flat[2:0]));
    uart_frame_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .in_data(t_data[1]), .in_valid(t_valid[1]),
        .in_ready(t_ready[1]), .serial_out(t_serial[1]), .busy(t_busy[1]), .fifo_count(t_count_flat[5:3]));
    uart_frame_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(2), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clock(clock), .reset(reset), .in_data(t_data[2]), .in_valid(t_valid[2]),
        .in_ready(t_ready[2]), .serial_out(t_serial[2]), .busy(t_busy[2]), .fifo_count(t_count_flat[8:6]));
    uart_frame_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clock(clock), .reset(reset), .in_data(t_data[3]), .in_valid(t_valid[3]),
        .in_ready(t_ready[3]), .serial_out(t_serial[3]), .busy(t_busy[3]), .fifo_count(t_count_flat[11:9]));

    // ---------------- reference model ----------------
    task automatic start_exp();
        exp_ser.delete();
        exp_busy.delete();
        exp_ser.push_back(1'b1);   // sample right after the push edge: still idle
        exp_busy.push_back(1'b0);
    endtask

    task automatic add_frame(input int s, input logic [7:0] d);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (cfg_par[s] != 0) bits.push_back((^d) ^ (cfg_par[s] == 2));
        for (int k = 0; k < cfg_stop[s]; k++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < cfg_cpb[s]; c++) begin
                exp_ser.push_back(bits[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic pad_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_ser.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    // ---------------- stimulus / capture ----------------
    task automatic push_seq(input int s, input logic [7:0] w [$]);
        foreach (w[i]) begin
            t_data[s]  = w[i];
            t_valid[s] = 1'b1;
            @(negedge clock);
        end
        t_valid[s] = 1'b0;
    endtask

    task automatic capture(input int s, input int n);
        cap_ser.delete();
        cap_busy.delete();
        cap_cnt.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cap_ser.push_back(t_serial[s]);
            cap_busy.push_back(t_busy[s]);
            cap_cnt.push_back(t_count_flat[3*s +: 3]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            n_tests++;
            if (t_serial[s] !== 1'b1) begin
                n_fail++; $display("FAIL reset_serial dut%0d: got %b want 1", s, t_serial[s]);
            end
            n_tests++;
            if (t_busy[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", s, t_busy[s]);
            end
            n_tests++;
            if (t_count_flat[3*s +: 3] !== 3'd0) begin
                n_fail++; $display("FAIL reset_count dut%0d: got %0d want 0", s, t_count_flat[3*s +: 3]);
            end
            n_tests++;
            if (t_ready[s] !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready dut%0d: got %b want 1", s, t_ready[s]);
            end
            $display("[TB] test_reset dut%0d checked", s);
        end
    endtask

    task automatic test_basic();
        logic [9:0] pat;
        logic [7:0] w;
        logic [7:0] ws [$];
        pat = 10'b1101001010;   // 0xA5 frame, first bit in position 0
        for (int rep = 0; rep < 3; rep++) begin
            w = (rep == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            ws.delete();
            ws.push_back(w);
            start_exp();
            add_frame(0, w);
            pad_exp(2);
            fork
                push_seq(0, ws);
                capture(0, exp_ser.size());
            join
            for (int i = 0; i < exp_ser.size(); i++) begin
                n_tests++;
                if (cap_ser[i] !== exp_ser[i]) begin
                    n_fail++; $display("FAIL basic_serial word %h sample %0d: got %b want %b", w, i, cap_ser[i], exp_ser[i]);
                end
                n_tests++;
                if (cap_busy[i] !== exp_busy[i]) begin
                    n_fail++; $display("FAIL basic_busy word %h sample %0d: got %b want %b", w, i, cap_busy[i], exp_busy[i]);
                end
            end
            n_tests++;
            if (cap_cnt[0] !== 3'd1) begin
                n_fail++; $display("FAIL basic_count_after_push: got %0d want 1", cap_cnt[0]);
            end
            n_tests++;
            if (cap_cnt[1] !== 3'd0) begin
                n_fail++; $display("FAIL basic_count_after_pop: got %0d want 0", cap_cnt[1]);
            end
            if (rep == 0) begin
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < 4; c++) begin
                        n_tests++;
                        if (cap_ser[1 + 4*b + c] !== pat[b]) begin
                            n_fail++; $display("FAIL basic_a5_bit%0d: got %b want %b", b, cap_ser[1 + 4*b + c], pat[b]);
                        end
                    end
                end
            end
            $display("[TB] test_basic word 0x%h frame checked", w);
        end
    endtask

    task automatic test_parity();
        int         ps   [5] = '{1, 1, 2, 1, 2};
        int         plit [5] = '{1, 0, 1, -1, -1};
        logic [7:0] pw   [5];
        logic [7:0] ws   [$];
        int         idx;
        pw[0] = 8'h07; pw[1] = 8'h03; pw[2] = 8'h00;
        pw[3] = 8'($urandom_range(0, 255)); pw[4] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 5; k++) begin
            ws.delete();
            ws.push_back(pw[k]);
            start_exp();
            add_frame(ps[k], pw[k]);
            pad_exp(2);
            fork
                push_seq(ps[k], ws);
                capture(ps[k], exp_ser.size());
            join
            for (int i = 0; i < exp_ser.size(); i++) begin
                n_tests++;
                if (cap_ser[i] !== exp_ser[i]) begin
                    n_fail++; $display("FAIL parity_serial dut%0d word %h sample %0d: got %b want %b", ps[k], pw[k], i, cap_ser[i], exp_ser[i]);
                end
                n_tests++;
                if (cap_busy[i] !== exp_busy[i]) begin
                    n_fail++; $display("FAIL parity_busy dut%0d word %h sample %0d: got %b want %b", ps[k], pw[k], i, cap_busy[i], exp_busy[i]);
                end
            end
            if (plit[k] >= 0) begin
                idx = 1 + 9 * cfg_cpb[ps[k]];
                for (int c = 0; c < cfg_cpb[ps[k]]; c++) begin
                    n_tests++;
                    if (cap_ser[idx + c] !== 1'(plit[k])) begin
                        n_fail++; $display("FAIL parity_bit dut%0d word %h: got %b want %0d", ps[k], pw[k], cap_ser[idx + c], plit[k]);
                    end
                end
            end
            $display("[TB] test_parity dut%0d word 0x%h frame checked", ps[k], pw[k]);
        end
    endtask

    task automatic test_fifo();
        logic [7:0] w [6];
        bit         saw_full;
        bit         timed_out;
        saw_full  = 1'b0;
        timed_out = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = 8'(($urandom_range(0, 15) << 4) | i);
        start_exp();
        for (int i = 0; i < 6; i++) add_frame(0, w[i]);
        pad_exp(2);
        fork
            begin
                int idx   = 0;
                int guard = 0;
                bit acc;
                t_data[0]  = w[0];
                t_valid[0] = 1'b1;
                while (idx < 6 && guard < 400) begin
                    acc = t_valid[0] && t_ready[0];
                    n_tests++;
                    if (t_ready[0] !== (t_count_flat[2:0] < 3'd4)) begin
                        n_fail++; $display("FAIL fifo_ready: got %b with count %0d", t_ready[0], t_count_flat[2:0]);
                    end
                    n_tests++;
                    if (t_count_flat[2:0] > 3'd4) begin
                        n_fail++; $display("FAIL fifo_overfill: got count %0d want <= 4", t_count_flat[2:0]);
                    end
                    if (t_count_flat[2:0] == 3'd4) saw_full = 1'b1;
                    @(negedge clock);
                    guard++;
                    if (acc) begin
                        idx++;
                        if (idx < 6) t_data[0] = w[idx];
                    end
                end
                t_valid[0] = 1'b0;
                if (idx != 6) timed_out = 1'b1;
            end
            capture(0, exp_ser.size());
        join
        n_tests++;
        if (timed_out) begin
            n_fail++; $display("FAIL fifo_accept_timeout: got not all accepted want 6 accepted");
        end
        n_tests++;
        if (!saw_full) begin
            n_fail++; $display("FAIL fifo_full_seen: got never full want count 4 reached");
        end
        for (int i = 0; i < exp_ser.size(); i++) begin
            n_tests++;
            if (cap_ser[i] !== exp_ser[i]) begin
                n_fail++; $display("FAIL fifo_serial sample %0d: got %b want %b", i, cap_ser[i], exp_ser[i]);
            end
            n_tests++;
            if (cap_busy[i] !== exp_busy[i]) begin
                n_fail++; $display("FAIL fifo_busy sample %0d: got %b want %b", i, cap_busy[i], exp_busy[i]);
            end
        end
        for (int i = 0; i < 6; i++) $display("[TB] test_fifo word %0d 0x%h frame checked", i, w[i]);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws [$];
        start_exp();
        for (int i = 0; i < 3; i++) begin
            ws.push_back(8'($urandom_range(0, 255)));
            add_frame(1, ws[i]);
        end
        pad_exp(2);
        fork
            push_seq(1, ws);
            capture(1, exp_ser.size());
        join
        for (int i = 0; i < exp_ser.size(); i++) begin
            n_tests++;
            if (cap_ser[i] !== exp_ser[i]) begin
                n_fail++; $display("FAIL b2b_serial sample %0d: got %b want %b", i, cap_ser[i], exp_ser[i]);
            end
            n_tests++;
            if (cap_busy[i] !== exp_busy[i]) begin
                n_fail++; $display("FAIL b2b_busy sample %0d: got %b want %b", i, cap_busy[i], exp_busy[i]);
            end
        end
        for (int i = 0; i < 3; i++) $display("[TB] test_back_to_back word 0x%h frame checked", ws[i]);
    endtask

    task automatic test_stop2();
        logic [7:0] ws [$];
        ws.push_back(8'hFF);
        ws.push_back(8'($urandom_range(0, 255)));
        start_exp();
        add_frame(3, ws[0]);
        add_frame(3, ws[1]);
        pad_exp(2);
        fork
            push_seq(3, ws);
            capture(3, exp_ser.size());
        join
        for (int i = 0; i < exp_ser.size(); i++) begin
            n_tests++;
            if (cap_ser[i] !== exp_ser[i]) begin
                n_fail++; $display("FAIL stop2_serial sample %0d: got %b want %b", i, cap_ser[i], exp_ser[i]);
            end
            n_tests++;
            if (cap_busy[i] !== exp_busy[i]) begin
                n_fail++; $display("FAIL stop2_busy sample %0d: got %b want %b", i, cap_busy[i], exp_busy[i]);
            end
        end
        n_tests++;
        if (cap_ser[1] !== 1'b0) begin
            n_fail++; $display("FAIL stop2_start: got %b want 0", cap_ser[1]);
        end
        for (int i = 2; i < 12; i++) begin
            n_tests++;
            if (cap_ser[i] !== 1'b1) begin
                n_fail++; $display("FAIL stop2_ones cycle %0d: got %b want 1", i, cap_ser[i]);
            end
        end
        n_tests++;
        if (cap_ser[12] !== 1'b0 || cap_busy[12] !== 1'b1) begin
            n_fail++; $display("FAIL stop2_next_start cycle 12: got serial %b busy %b want 0 1", cap_ser[12], cap_busy[12]);
        end
        for (int i = 0; i < 2; i++) $display("[TB] test_stop2 word 0x%h frame checked", ws[i]);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ws [$];
        for (int i = 0; i < 3; i++) ws.push_back(8'($urandom_range(0, 255)));
        push_seq(0, ws);
        repeat (10) @(negedge clock);   // now inside the data bits of frame 1
        n_tests++;
        if (t_count_flat[2:0] !== 3'd2 || t_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got count %0d busy %b want 2 1", t_count_flat[2:0], t_busy[0]);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (t_serial[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_serial: got %b want 1", t_serial[0]);
        end
        n_tests++;
        if (t_count_flat[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_count: got %0d want 0", t_count_flat[2:0]);
        end
        n_tests++;
        if (t_busy[0] !== 1'b0 || t_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy_ready: got %b %b want 0 1", t_busy[0], t_ready[0]);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            n_tests++;
            if (t_serial[0] !== 1'b1 || t_busy[0] !== 1'b0 || t_count_flat[2:0] !== 3'd0) begin
                n_fail++; $display("FAIL rstmid_idle cycle %0d: got serial %b busy %b count %0d want 1 0 0",
                                   i, t_serial[0], t_busy[0], t_count_flat[2:0]);
            end
        end
        $display("[TB] test_reset_mid reset during frame checked");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        t_valid = 4'b0;
        for (int s = 0; s < 4; s++) t_data[s] = 8'h00;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_basic();
        test_parity();
        test_fifo();
        test_back_to_back();
        test_stop2();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
